// File: rtl/mul16_seq_pkg.sv
// Shared types and helpers for the mul16 sequencer.
// Optional build macro: MUL16_ZERO_SKIP_EN (zero-byte slot skipping, used by mul16_seq_ctrl).
package mul16_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        SUM   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_LL = 2'd0;
    localparam slot_t SLOT_LH = 2'd1;
    localparam slot_t SLOT_HL = 2'd2;
    localparam slot_t SLOT_HH = 2'd3;

    // Issue order tables, position 0 in bits [1:0].
    localparam logic [7:0] ORDER_LL_FIRST = {SLOT_HH, SLOT_HL, SLOT_LH, SLOT_LL};
    localparam logic [7:0] ORDER_LH_FIRST = {SLOT_HH, SLOT_LL, SLOT_HL, SLOT_LH};

    typedef struct packed {
        logic  found;
        slot_t slot;
    } pick_t;

    function automatic slot_t order_slot(input logic lh_first, input logic [1:0] pos);
        logic [7:0] tbl;
        tbl = lh_first ? ORDER_LH_FIRST : ORDER_LL_FIRST;
        return tbl[{pos, 1'b0} +: 2];
    endfunction

    // Earliest slot, in issue order, whose bit is set in the pending mask.
    function automatic pick_t first_pending(input logic lh_first, input logic [3:0] pending);
        pick_t r;
        slot_t s;
        r.found = 1'b0;
        r.slot  = SLOT_LL;
        for (int p = 3; p >= 0; p--) begin
            s = order_slot(lh_first, 2'(p));
            if (pending[s]) begin
                r.found = 1'b1;
                r.slot  = s;
            end
        end
        return r;
    endfunction

    // Slot id bit 1 selects the byte of a, bit 0 the byte of b.
    function automatic logic [7:0] slot_a_byte(input logic [15:0] x, input slot_t s);
        return s[1] ? x[15:8] : x[7:0];
    endfunction

    function automatic logic [7:0] slot_b_byte(input logic [15:0] x, input slot_t s);
        return s[0] ? x[15:8] : x[7:0];
    endfunction

endpackage

// File: rtl/mul16_cap_pipe.sv
// Delay line of {valid, slot_id} matching the shared multiplier latency.
// DEPTH=0 passes the issue straight through so capture happens in the issue cycle.
module mul16_cap_pipe
    import mul16_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  slot_t in_slot,
    output logic  out_valid,
    output slot_t out_slot,
    output logic  more
);

    if (DEPTH == 0) begin : g_comb
        assign out_valid = in_valid;
        assign out_slot  = in_slot;
        assign more      = 1'b0;
    end else begin : g_reg
        logic [DEPTH-1:0] v_q;
        slot_t            s_q [DEPTH];

        // Shift issue tags toward the capture point; reset drops all in-flight entries.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                for (int i = 0; i < DEPTH; i++) s_q[i] <= SLOT_LL;
            end else begin
                v_q[0] <= in_valid;
                s_q[0] <= in_slot;
                for (int i = 1; i < DEPTH; i++) begin
                    v_q[i] <= v_q[i-1];
                    s_q[i] <= s_q[i-1];
                end
            end
        end

        assign out_valid = v_q[DEPTH-1];
        assign out_slot  = s_q[DEPTH-1];

        // Entries that will still be in flight after the next edge (exiting stage excluded).
        always_comb begin
            more = 1'b0;
            for (int i = 0; i < DEPTH - 1; i++) more = more | v_q[i];
        end
    end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequencer for a 16x16 multiply built from one shared 8x8 multiplier.
// Issues the four byte products, captures the partials for the external adder,
// registers the adder output and returns it over valid/ready.
// Optional build macro: MUL16_ZERO_SKIP_EN skips slots with a zero operand byte.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// the source holds its data stable while valid is high and ready is low.
module mul16_seq_ctrl
    import mul16_seq_pkg::*;
#(
    parameter int MUL_LAT             = 1,
    parameter bit SLOT_ORDER_LH_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        mul_en,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic [15:0] ll,
    output logic [15:0] lh,
    output logic [15:0] hl,
    output logic [15:0] hh,
    input  logic [31:0] sum_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic [3:0]  pending, acc_mask, pend_after;
    slot_t       cur_slot, cap_slot;
    pick_t       acc_pick, iss_pick;
    logic        accept, cap_valid, cap_more;

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // Slot masks: what a new pair needs issued, and what remains after the current issue.
    always_comb begin
        acc_mask = 4'b1111;
`ifdef MUL16_ZERO_SKIP_EN
        for (int s = 0; s < 4; s++) begin
            if (slot_a_byte(a, slot_t'(s)) == 8'h00 || slot_b_byte(b, slot_t'(s)) == 8'h00)
                acc_mask[s] = 1'b0;
        end
`endif
        pend_after = pending & ~(4'b0001 << cur_slot);
        acc_pick   = first_pending(SLOT_ORDER_LH_FIRST, acc_mask);
        iss_pick   = first_pending(SLOT_ORDER_LH_FIRST, pend_after);
    end

    // Next-state and handshake/issue strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = acc_pick.found ? ISSUE : SUM;
            end
            ISSUE: begin
                mul_en = 1'b1;
                if (!iss_pick.found) state_nxt = (MUL_LAT > 0) ? DRAIN : SUM;
            end
            DRAIN: begin
                if (!cap_more) state_nxt = SUM;
            end
            SUM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand latch and issue registers; mul_a/mul_b are loaded on the edge
    // entering each issue cycle and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            pending  <= '0;
            cur_slot <= SLOT_LL;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                pending  <= acc_mask;
                cur_slot <= acc_pick.slot;
                if (acc_pick.found) begin
                    mul_a <= slot_a_byte(a, acc_pick.slot);
                    mul_b <= slot_b_byte(b, acc_pick.slot);
                end
            end else if (state == ISSUE) begin
                pending <= pend_after;
                if (iss_pick.found) begin
                    cur_slot <= iss_pick.slot;
                    mul_a    <= slot_a_byte(a_q, iss_pick.slot);
                    mul_b    <= slot_b_byte(b_q, iss_pick.slot);
                end
            end
        end
    end

    mul16_cap_pipe #(.DEPTH(MUL_LAT)) u_cap_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mul_en),
        .in_slot   (cur_slot),
        .out_valid (cap_valid),
        .out_slot  (cap_slot),
        .more      (cap_more)
    );

    // Partials: cleared on acceptance, written only when a tagged product arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll <= '0;
            lh <= '0;
            hl <= '0;
            hh <= '0;
        end else if (accept) begin
            ll <= '0;
            lh <= '0;
            hl <= '0;
            hh <= '0;
        end else if (cap_valid) begin
            case (cap_slot)
                SLOT_LL: ll <= mul_p;
                SLOT_LH: lh <= mul_p;
                SLOT_HL: hl <= mul_p;
                default: hh <= mul_p;
            endcase
        end
    end

    // Result register takes the adder output once all partials have settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) result <= '0;
        else if (state == SUM) result <= sum_in;
    end

endmodule
